// File: rtl/reg_file_32x32_pkg.sv
// Shared register-file constants and types, also used by the datapath top
// and the operand-select mux stage.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/reg_file_32x32_if.sv
// Read/write bus of the register file. The datapath drives addresses and
// write-back data (master); the register file returns read data (slave).
interface reg_file_32x32_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  rd_data1, rd_data2
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output rd_data1, rd_data2
  );

endinterface : reg_file_32x32_if

// File: rtl/reg_file_32x32_read_port.sv
// One combinational read port: storage select, register-0 forcing and,
// when REGFILE_BYPASS_EN is defined, write-through bypass of the data
// being written this cycle.
module regfile_read_port #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DEPTH  = regfile_pkg::DEPTH
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          reset,
  output logic [DATA_W-1:0]             data
);

  import regfile_pkg::*;

`ifndef REGFILE_BYPASS_EN
  // Write-side inputs only matter for the bypass build.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data, reset};
`endif

  // Select stored value, optionally override with in-flight write, and
  // force register 0 to read as zero last so nothing can leak through it.
  always_comb begin
    data = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (!reset && wr_en && (wr_addr != ADDR_W'(REG_ZERO)) && (wr_addr == addr)) begin
      data = wr_data;
    end
`endif
    if (addr == ADDR_W'(REG_ZERO)) begin
      data = '0;
    end
  end

endmodule : regfile_read_port

// File: rtl/reg_file_32x32.sv
// 32 x 32-bit register file with two combinational read ports and one
// synchronous write port; register 0 is hardwired to zero.
// Optional feature: define REGFILE_BYPASS_EN for write-through bypass on
// both read ports.
module reg_file_32x32 #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DEPTH  = regfile_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_32x32_if.slave  bus
);

  import regfile_pkg::*;

  logic [DEPTH-1:0][DATA_W-1:0] regs;

  // Synchronous reset clears everything and wins over a same-edge write;
  // writes to register 0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (bus.wr_en && (bus.wr_addr != ADDR_W'(REG_ZERO))) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_port1 (
    .addr    (bus.rd_addr1),
    .regs    (regs),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .reset   (reset),
    .data    (bus.rd_data1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_port2 (
    .addr    (bus.rd_addr2),
    .regs    (regs),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .reset   (reset),
    .data    (bus.rd_data2)
  );

endmodule : reg_file_32x32

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32. Expected values are hand-computed;
// same-cycle read-during-write expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_32x32;

  import regfile_pkg::*;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  reg_file_32x32_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_32x32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a single write, one edge, then idle the write port.
  task automatic do_write(input reg_addr_t a, input reg_data_t d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
  endtask

  // Set both read addresses and let the combinational path settle.
  task automatic set_read(input reg_addr_t a1, input reg_addr_t a2);
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_read(reg_addr_t'(i), reg_addr_t'(DEPTH - 1 - i));
      n_total++;
      if (bus.rd_data1 !== 32'h0) $display("FAIL reset_p1 idx=%0d got=%h exp=%h", i, bus.rd_data1, 32'h0);
      else n_pass++;
      n_total++;
      if (bus.rd_data2 !== 32'h0) $display("FAIL reset_p2 idx=%0d got=%h exp=%h", DEPTH - 1 - i, bus.rd_data2, 32'h0);
      else n_pass++;
    end
  endtask

  task automatic test_write_read;
    do_write(5'd5, 32'hDEAD_BEEF);
    set_read(5'd5, 5'd5);
    n_total++;
    if (bus.rd_data1 !== 32'hDEAD_BEEF) $display("FAIL wr_r5_p1 got=%h exp=%h", bus.rd_data1, 32'hDEAD_BEEF);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'hDEAD_BEEF) $display("FAIL wr_r5_p2 got=%h exp=%h", bus.rd_data2, 32'hDEAD_BEEF);
    else n_pass++;
    set_read(5'd6, 5'd4);
    n_total++;
    if (bus.rd_data1 !== 32'h0) $display("FAIL wr_r6_untouched got=%h exp=%h", bus.rd_data1, 32'h0);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'h0) $display("FAIL wr_r4_untouched got=%h exp=%h", bus.rd_data2, 32'h0);
    else n_pass++;
  endtask

  task automatic test_r0;
    do_write(5'd0, 32'h1234_5678);
    set_read(5'd0, 5'd0);
    n_total++;
    if (bus.rd_data1 !== 32'h0) $display("FAIL r0_p1 got=%h exp=%h", bus.rd_data1, 32'h0);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'h0) $display("FAIL r0_p2 got=%h exp=%h", bus.rd_data2, 32'h0);
    else n_pass++;
    set_read(5'd5, 5'd0);
    n_total++;
    if (bus.rd_data1 !== 32'hDEAD_BEEF) $display("FAIL r0_keeps_r5 got=%h exp=%h", bus.rd_data1, 32'hDEAD_BEEF);
    else n_pass++;
  endtask

  task automatic test_same_cycle;
    reg_data_t exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5_A5A5;
`else
    exp_same = 32'h1111_1111;
`endif
    do_write(5'd7, 32'h1111_1111);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'hA5A5_A5A5;
    set_read(5'd7, 5'd5);
    n_total++;
    if (bus.rd_data1 !== exp_same) $display("FAIL same_cycle_p1 got=%h exp=%h", bus.rd_data1, exp_same);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'hDEAD_BEEF) $display("FAIL same_cycle_other_p2 got=%h exp=%h", bus.rd_data2, 32'hDEAD_BEEF);
    else n_pass++;
    set_read(5'd5, 5'd7);
    n_total++;
    if (bus.rd_data2 !== exp_same) $display("FAIL same_cycle_p2 got=%h exp=%h", bus.rd_data2, exp_same);
    else n_pass++;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    set_read(5'd7, 5'd7);
    n_total++;
    if (bus.rd_data1 !== 32'hA5A5_A5A5) $display("FAIL after_edge_p1 got=%h exp=%h", bus.rd_data1, 32'hA5A5_A5A5);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'hA5A5_A5A5) $display("FAIL after_edge_p2 got=%h exp=%h", bus.rd_data2, 32'hA5A5_A5A5);
    else n_pass++;
  endtask

  task automatic test_reset_dominates;
    @(negedge clk);
    reset       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 32'hFFFF_FFFF;
    set_read(5'd9, 5'd9);
    n_total++;
    if (bus.rd_data1 !== 32'h0) $display("FAIL rst_bypass_p1 got=%h exp=%h", bus.rd_data1, 32'h0);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'h0) $display("FAIL rst_bypass_p2 got=%h exp=%h", bus.rd_data2, 32'h0);
    else n_pass++;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    set_read(5'd9, 5'd7);
    n_total++;
    if (bus.rd_data1 !== 32'h0) $display("FAIL rst_r9 got=%h exp=%h", bus.rd_data1, 32'h0);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'h0) $display("FAIL rst_clears_r7 got=%h exp=%h", bus.rd_data2, 32'h0);
    else n_pass++;
    set_read(5'd5, 5'd31);
    n_total++;
    if (bus.rd_data1 !== 32'h0) $display("FAIL rst_clears_r5 got=%h exp=%h", bus.rd_data1, 32'h0);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_write(5'd3, 32'h0000_0001);
    do_write(5'd4, 32'h0000_0002);
    do_write(5'd31, 32'h8000_0000);
    set_read(5'd3, 5'd4);
    n_total++;
    if (bus.rd_data1 !== 32'h0000_0001) $display("FAIL b2b_r3 got=%h exp=%h", bus.rd_data1, 32'h1);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'h0000_0002) $display("FAIL b2b_r4 got=%h exp=%h", bus.rd_data2, 32'h2);
    else n_pass++;
    set_read(5'd31, 5'd3);
    n_total++;
    if (bus.rd_data1 !== 32'h8000_0000) $display("FAIL b2b_r31 got=%h exp=%h", bus.rd_data1, 32'h8000_0000);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'h0000_0001) $display("FAIL b2b_r3_p2 got=%h exp=%h", bus.rd_data2, 32'h1);
    else n_pass++;
    do_write(5'd10, 32'hCAFE_0001);
    do_write(5'd10, 32'hCAFE_0002);
    set_read(5'd10, 5'd10);
    n_total++;
    if (bus.rd_data1 !== 32'hCAFE_0002) $display("FAIL last_wins_p1 got=%h exp=%h", bus.rd_data1, 32'hCAFE_0002);
    else n_pass++;
    n_total++;
    if (bus.rd_data2 !== 32'hCAFE_0002) $display("FAIL last_wins_p2 got=%h exp=%h", bus.rd_data2, 32'hCAFE_0002);
    else n_pass++;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    test_reset();
    test_write_read();
    test_r0();
    test_same_cycle();
    test_reset_dominates();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_file_32x32

// File: doc/reg_file_32x32.md
# reg_file_32x32

Thirty-two-entry, 32-bit general-purpose register file for the lab datapath. It sits directly upstream of the 32-bit 2:1 operand-select mux (`mux2to1_32bits`).
- Read port 1 drives the ALU A operand.
- Read port 2 drives one input of the operand-select mux; the sign-extended immediate drives the other.
- Write-back data arrives from the result stage.

Register 0 reads as zero at all times.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: register-address width.
- `DEPTH`, default 32: number of registers; must equal 2**`ADDR_W`.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous, active-high; clears every register.
- `rd_addr1`  in  `ADDR_W`  read-port-1 register index.
- `rd_addr2`  in  `ADDR_W`  read-port-2 register index.
- `rd_data1`  out  `DATA_W`  read-port-1 data (to ALU A).
- `rd_data2`  out  `DATA_W`  read-port-2 data (to operand-select mux `in1`).
- `wr_en`  in  1  write enable.
- `wr_addr`  in  `ADDR_W`  write register index.
- `wr_data`  in  `DATA_W`  write-back data.

## Operation
- Storage: `DEPTH` registers of `DATA_W` bits each.
- Reads are combinational. `rd_dataN` = `regs[rd_addrN]`.
- Register 0:
  - A read of index 0 returns 0 unconditionally.
  - A write to index 0 is discarded and has no effect.
- Write: on a rising `clk` edge, if `reset` = 0, `wr_en` = 1 and `wr_addr` ≠ 0, then `regs[wr_addr]` ← `wr_data`. Nothing else changes.
- Reset: on a rising `clk` edge with `reset` = 1, all registers ← 0.
  - Reset dominates: a write presented on the same edge is dropped.
- Reset mid-operation: contents are lost. The first post-reset read of any index returns 0.
- Both read ports may address the same register, or the write index, in the same cycle; there is no conflict and no arbitration.
- Out-of-range addresses are impossible because `DEPTH` = 2**`ADDR_W`.

## Timing
- Read latency is 0 cycles, from address to data, combinationally.
- Write latency is 1 edge: data written at edge N is visible on the read ports after edge N.
  - Without bypass, a same-cycle read of the write index returns the old value.
- Outputs after reset: `rd_data1` = `rd_data2` = 0 for every address, until the first write.
- There is no handshake. `wr_en` is sampled on every edge, and `wr_en`/`wr_addr`/`wr_data` must be stable around the edge.
- Back-to-back writes to the same index on consecutive edges: the last one wins.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined:
  - Write-through bypass on each read port.
  - If `wr_en` = 1, `wr_addr` ≠ 0, `wr_addr` = `rd_addrN` and `reset` = 0, then `rd_dataN` = `wr_data` in the same cycle, combinationally.
  - The stored value still updates on the edge.
  - Bypass is suppressed while `reset` = 1.
- Undefined: no bypass. Reads always return stored contents.

## Structure
- Shared package `regfile_pkg`:
  - Constants `DATA_W` = 32, `ADDR_W` = 5, `DEPTH` = 32.
  - `REG_ZERO` = 5'd0.
  - Typedefs `reg_addr_t` (`ADDR_W` bits) and `reg_data_t` (`DATA_W` bits).
  - These are shared with the datapath top and the mux stage.
- One sub-module, `regfile_read_port`, instantiated twice.
  - Function: zero-check, storage select, and (under the macro) bypass compare and select.
  - Inputs: address, storage array view, `wr_en`, `wr_addr`, `wr_data`, `reset`.
  - Output: data.

## Test plan
- Reset, then read all 32 indices on both ports -> every read = 0x00000000.
- Write 0xDEADBEEF to r5, then the next cycle read r5 on port 1 and r5 on port 2 -> both = 0xDEADBEEF.
- Write 0x12345678 to r0, then read r0 -> 0x00000000.
- Same-cycle write of 0xA5A5A5A5 to r7 with `rd_addr1` = 7, where r7 previously held 0x11111111:
  - With `REGFILE_BYPASS_EN`: `rd_data1` = 0xA5A5A5A5 in that cycle.
  - Without the macro: `rd_data1` = 0x11111111 in that cycle.
  - Either way: 0xA5A5A5A5 after the edge.
- Assert `reset` together with `wr_en` = 1, `wr_addr` = 9, `wr_data` = 0xFFFFFFFF -> r9 reads 0 after the edge.
  - With the macro, the bypass output is also 0 during that cycle.
- Write r3 = 1, r4 = 2, r31 = 0x80000000 on consecutive edges, then read pairs (3,4) and (31,3) -> (1,2) and (0x80000000,1).
